alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver_if.sv | 45 ++++
 rtl/alu_driver.sv | 173 +++++++++++++++++
 tb/tb_alu_driver.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_driver_if.sv
// -----------------------------------------------------------------------------
// alu_driver_if
// Bundles the command, add/sub unit and response signals of alu_driver.
//   slave  : the alu_driver side (accepts commands, drives ALU operands,
//            presents responses)
//   master : the environment side (offers commands, returns the ALU result,
//            consumes responses)
// Signals:
//   cmd_valid/cmd_ready, cmd_a, cmd_b, cmd_op    command handshake and payload
//   alu_a, alu_b, alu_op, alu_result             add/sub unit operands/result
//   rsp_valid/rsp_ready, rsp_result, rsp_err     response handshake and payload
//   rsp_count                                    response FIFO occupancy
// -----------------------------------------------------------------------------
interface alu_driver_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic          cmd_op;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic          alu_op;
  logic [4:0]    alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [4:0]    rsp_result;
  logic          rsp_err;
  logic [CW-1:0] rsp_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_err,
           rsp_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_err,
           rsp_count
  );
endinterface

// File: rtl/alu_driver.sv
// -----------------------------------------------------------------------------
// alu_driver
// Queues add/subtract commands, drives them one at a time into an external
// registered add/sub unit, checks the returned result against an internally
// computed expected value and queues {result, mismatch} responses.
// Ports:
//   i_clk   : single clock, rising edge
//   i_rst_n : asynchronous active-low reset (release synchronised internally)
//   bus     : alu_driver_if.slave (command, ALU and response signals)
// Parameter:
//   DEPTH   : entries in each of the command and response FIFOs (power of 2, >=2)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a queued command and space in the response FIFO
// ST_DRIVE   | operands on alu_*, add/sub unit registers its result
// ST_CAPTURE | alu_result valid, pushed with mismatch flag on leaving
// -----------------------------------------------------------------------------
module alu_driver #(
  parameter int DEPTH = 4
) (
  input logic         i_clk,
  input logic         i_rst_n,
  alu_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // Release synchroniser: assertion is immediate, activity starts two edges
  // after release.
  logic [1:0] r_rst_sync;
  logic       w_run;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run = r_rst_sync[1];

  // Command FIFO
  logic [8:0]    r_cmd_mem [DEPTH];
  logic [AW-1:0] r_cmd_wr;
  logic [AW-1:0] r_cmd_rd;
  logic [AW:0]   r_cmd_cnt;
  logic          w_cmd_full;
  logic          w_cmd_empty;
  logic          w_cmd_ready;
  logic          w_cmd_push;
  logic          w_cmd_pop;
  logic [8:0]    w_cmd_head;

  // Response FIFO
  logic [5:0]    r_rsp_mem [DEPTH];
  logic [AW-1:0] r_rsp_wr;
  logic [AW-1:0] r_rsp_rd;
  logic [AW:0]   r_rsp_cnt;
  logic          w_rsp_full;
  logic          w_rsp_valid;
  logic          w_rsp_push;
  logic          w_rsp_pop;

  // FSM and ALU drive
  logic [1:0]    r_state;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic          r_alu_op;
  logic [4:0]    r_exp;
  logic          w_issue;
  logic [4:0]    w_exp;

  assign w_cmd_full  = (r_cmd_cnt == FULL_CNT);
  assign w_cmd_empty = (r_cmd_cnt == '0);
  // Ready reads 1 while reset is held, then 0 until the synchroniser
  // releases, so nothing is accepted before the block is running.
  assign w_cmd_ready = ~w_cmd_full & (w_run | ~i_rst_n);
  assign w_cmd_push  = bus.cmd_valid & w_cmd_ready;
  assign w_cmd_pop   = w_issue;
  assign w_cmd_head  = r_cmd_mem[r_cmd_rd];

  assign w_rsp_full  = (r_rsp_cnt == FULL_CNT);
  assign w_rsp_valid = (r_rsp_cnt != '0);
  assign w_rsp_push  = (r_state == ST_CAPTURE);
  assign w_rsp_pop   = w_rsp_valid & bus.rsp_ready;

  // Issue only with space for the response; with a single op in flight the
  // response FIFO can then never overflow.
  assign w_issue = (r_state == ST_IDLE) & ~w_cmd_empty & ~w_rsp_full & w_run;

  // head layout: {op, a, b}; 5-bit modulo-32 result
  assign w_exp = w_cmd_head[8] ? ({1'b0, w_cmd_head[7:4]} - {1'b0, w_cmd_head[3:0]})
                               : ({1'b0, w_cmd_head[7:4]} + {1'b0, w_cmd_head[3:0]});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_wr  <= '0;
      r_cmd_rd  <= '0;
      r_cmd_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_cmd_mem[i] <= '0;
    end else begin
      if (w_cmd_push) begin
        r_cmd_mem[r_cmd_wr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        r_cmd_wr            <= r_cmd_wr + ONE_PTR;
      end
      if (w_cmd_pop) r_cmd_rd <= r_cmd_rd + ONE_PTR;
      case ({w_cmd_push, w_cmd_pop})
        2'b10:   r_cmd_cnt <= r_cmd_cnt + ONE_CNT;
        2'b01:   r_cmd_cnt <= r_cmd_cnt - ONE_CNT;
        default: r_cmd_cnt <= r_cmd_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= 1'b0;
      r_exp    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state  <= ST_DRIVE;
            r_alu_op <= w_cmd_head[8];
            r_alu_a  <= w_cmd_head[7:4];
            r_alu_b  <= w_cmd_head[3:0];
            r_exp    <= w_exp;
          end
        end
        ST_DRIVE:   r_state <= ST_CAPTURE;
        ST_CAPTURE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_wr  <= '0;
      r_rsp_rd  <= '0;
      r_rsp_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_rsp_mem[i] <= '0;
    end else begin
      if (w_rsp_push) begin
        r_rsp_mem[r_rsp_wr] <= {bus.alu_result, (bus.alu_result != r_exp)};
        r_rsp_wr            <= r_rsp_wr + ONE_PTR;
      end
      if (w_rsp_pop) r_rsp_rd <= r_rsp_rd + ONE_PTR;
      case ({w_rsp_push, w_rsp_pop})
        2'b10:   r_rsp_cnt <= r_rsp_cnt + ONE_CNT;
        2'b01:   r_rsp_cnt <= r_rsp_cnt - ONE_CNT;
        default: r_rsp_cnt <= r_rsp_cnt;
      endcase
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_op     = r_alu_op;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_rsp_mem[r_rsp_rd][5:1];
  assign bus.rsp_err    = r_rsp_mem[r_rsp_rd][0];
  assign bus.rsp_count  = r_rsp_cnt;
endmodule

// File: tb/tb_alu_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_driver
// Directed bench for alu_driver (DEPTH=4) with a registered add/sub unit model
// that can be told to return a wrong result.
// -----------------------------------------------------------------------------
module tb_alu_driver;
  logic clk;
  logic rst_n;
  logic clk_en;
  logic fault;
  int   n_assert;
  int   n_fail;

  alu_driver_if #(.DEPTH(4)) bus ();

  alu_driver #(.DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // External registered add/sub unit
  always @(posedge clk) begin
    bus.alu_result <= (bus.alu_op ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                                  : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b}))
                      + {4'd0, fault};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic op);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    do begin
      ok = bus.cmd_ready;
      tick();
      n++;
    end while (!ok && n < 200);
    bus.cmd_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic pop_chk(input string tag, input logic [4:0] res, input logic err);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    n_assert      = 0;
    n_fail        = 0;
    fault         = 1'b0;
    clk_en        = 1'b0;
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 4'd0;
    bus.cmd_b     = 4'd0;
    bus.cmd_op    = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset with the clock stopped
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_count", 32'(bus.rsp_count), 32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);

    // Release is synchronised: ready only after the second edge
    #5 rst_n = 1'b1;
    #1;
    chk("sync_ready_r0", 32'(bus.cmd_ready), 32'd0);
    clk_en = 1'b1;
    tick();
    chk("sync_ready_r1", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("sync_ready_r2", 32'(bus.cmd_ready), 32'd1);

    // Single add 3+1 accepted at E0
    push_cmd(4'd3, 4'd1, 1'b0);
    chk("add_alu_a_e0", 32'(bus.alu_a), 32'd0);
    tick();
    chk("add_alu_a_e1", 32'(bus.alu_a), 32'd3);
    chk("add_alu_b_e1", 32'(bus.alu_b), 32'd1);
    chk("add_alu_op_e1", 32'(bus.alu_op), 32'd0);
    tick();
    chk("add_rsp_valid_e2", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("add_rsp_valid_e3", 32'(bus.rsp_valid), 32'd1);
    chk("add_rsp_count_e3", 32'(bus.rsp_count), 32'd1);
    pop_chk("add", 5'd4, 1'b0);
    chk("add_drained", 32'(bus.rsp_valid), 32'd0);

    // Sequence, one op per 3 cycles
    push_cmd(4'd3, 4'd1, 1'b1);
    push_cmd(4'd3, 4'd0, 1'b1);
    push_cmd(4'd0, 4'd1, 1'b1);
    push_cmd(4'd15, 4'd15, 1'b0);
    n = 0;
    while (bus.rsp_count != 3'd4 && n < 50) begin
      tick();
      n++;
    end
    chk("seq_cycles", 32'(n), 32'd9);
    pop_chk("seq0", 5'd2, 1'b0);
    pop_chk("seq1", 5'd3, 1'b0);
    pop_chk("seq2", 5'd31, 1'b0);
    pop_chk("seq3", 5'd30, 1'b0);

    // Backpressure: 9 commands, responses held
    fork
      begin
        for (int i = 0; i < 9; i++) push_cmd(4'(i), 4'd1, 1'b0);
      end
    join_none
    repeat (40) tick();
    chk("bp_rsp_count", 32'(bus.rsp_count), 32'd4);
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < 9; i++) pop_chk($sformatf("bp%0d", i), 5'(i + 1), 1'b0);
    chk("bp_empty", 32'(bus.rsp_count), 32'd0);

    // Mismatch: unit returns expected+1
    fault = 1'b1;
    push_cmd(4'd2, 4'd2, 1'b0);
    pop_chk("mismatch", 5'd5, 1'b1);
    fault = 1'b0;

    // Async reset mid-DRIVE with two commands queued
    push_cmd(4'd1, 4'd1, 1'b0);
    push_cmd(4'd2, 4'd2, 1'b0);
    push_cmd(4'd3, 4'd3, 1'b0);
    push_cmd(4'd4, 4'd4, 1'b0);
    tick();
    chk("mid_drive_alu_a", 32'(bus.alu_a), 32'd2);
    chk("mid_rsp_count", 32'(bus.rsp_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("arst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_rsp_count", 32'(bus.rsp_count), 32'd0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    #2 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    bus.rsp_ready = 1'b0;
    chk("arst_no_rsp", 32'(seen), 32'd0);
    chk("arst_alu_idle", 32'(bus.alu_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
